// File: rtl/pipe_tag_ctrl.sv
// Pipeline tag controller: carries {rf_we, wR, opcode} tags through the
// ID/EX, EX/MEM and MEM/WB registers, handles load-use stalls, branch
// flushes and data-memory wait states, and counts stall cycles.
module pipe_tag_ctrl #(
    parameter logic [6:0] OPCODE_LW  = 7'b0000011,
    parameter logic [6:0] OPCODE_NOP = 7'b0010011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_rf_we,
    input  logic [4:0]  id_wR,
    input  logic [6:0]  id_opcode,
    input  logic        load_use_hazard,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        rf_we_from_ex,
    output logic [4:0]  wR_from_ex,
    output logic [6:0]  opcode_from_ex,
    output logic        rf_we_from_mem,
    output logic [4:0]  wR_from_mem,
    output logic        rf_we_from_wb,
    output logic [4:0]  wR_from_wb,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        mem_wait,
    output logic [15:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        freeze_s;
    logic        flush_req_s;
    logic        stall_s;
    logic        branch_pending_r;
    logic        ex_rf_we_next_s;
    logic [4:0]  ex_wR_next_s;
    logic [6:0]  ex_opcode_next_s;

    // Memory freeze and front-end control decode.
    always_comb begin
        freeze_s    = mem_req & ~mem_ready;
        flush_req_s = branch_taken | branch_pending_r;
        stall_s     = freeze_s | (load_use_hazard & ~flush_req_s);
        pc_stall    = stall_s;
        ifid_stall  = stall_s;
        ifid_flush  = flush_req_s & ~freeze_s;
    end

    // Next ID/EX tag: flush beats load-use, invalid ID slots become bubbles.
    // OPCODE_LW passes through like any other opcode so the consumer can spot
    // a load sitting in EX.
    always_comb begin
        ex_rf_we_next_s  = 1'b0;
        ex_wR_next_s     = 5'd0;
        ex_opcode_next_s = OPCODE_NOP;
        if (flush_req_s) begin
            ex_rf_we_next_s  = 1'b0;
            ex_wR_next_s     = 5'd0;
            ex_opcode_next_s = OPCODE_NOP;
        end else if (load_use_hazard) begin
            ex_rf_we_next_s  = 1'b0;
            ex_wR_next_s     = 5'd0;
            ex_opcode_next_s = OPCODE_NOP;
        end else if (id_valid) begin
            ex_rf_we_next_s  = id_rf_we;
            ex_wR_next_s     = id_wR;
            ex_opcode_next_s = (id_opcode == OPCODE_LW) ? OPCODE_LW : id_opcode;
        end else begin
            ex_rf_we_next_s  = 1'b0;
            ex_wR_next_s     = 5'd0;
            ex_opcode_next_s = OPCODE_NOP;
        end
    end

    // RUN/WAIT next-state logic; mem_wait reflects the WAIT state.
    always_comb begin
        state_next_s = state_r;
        mem_wait     = (state_r == ST_WAIT);
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Remember a branch resolved during a freeze until the pipe unfreezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_pending_r <= 1'b0;
        end else if (freeze_s) begin
            branch_pending_r <= branch_pending_r | branch_taken;
        end else begin
            branch_pending_r <= 1'b0;
        end
    end

    // Tag pipeline: freeze holds ID/EX and EX/MEM and drains a bubble into WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_from_ex  <= 1'b0;
            wR_from_ex     <= 5'd0;
            opcode_from_ex <= OPCODE_NOP;
            rf_we_from_mem <= 1'b0;
            wR_from_mem    <= 5'd0;
            rf_we_from_wb  <= 1'b0;
            wR_from_wb     <= 5'd0;
        end else if (freeze_s) begin
            rf_we_from_wb  <= 1'b0;
            wR_from_wb     <= 5'd0;
        end else begin
            rf_we_from_ex  <= ex_rf_we_next_s;
            wR_from_ex     <= ex_wR_next_s;
            opcode_from_ex <= ex_opcode_next_s;
            rf_we_from_mem <= rf_we_from_ex;
            wR_from_mem    <= wR_from_ex;
            rf_we_from_wb  <= rf_we_from_mem;
            wR_from_wb     <= wR_from_mem;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (stall_s && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule
